// File: rtl/adc_sample_averager_pkg.sv
// Shared defaults and helpers for the ADC block averager: word width, channel count,
// maximum block length and a width helper that never returns zero.
package adc_sample_averager_pkg;

    localparam int W_ADC       = 18;
    localparam int N_ADC_CHAN  = 8;
    localparam int MAX_AVG_LOG = 7;

    // Index width that stays at least 1 bit, so single-entry ranges remain legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_sample_averager_chan_accum.sv
// One channel of the block averager: accumulates captured words, produces the floored
// block mean, and tracks the pending-result and sticky overrun flags.
module adc_sample_averager_chan_accum #(
    parameter int W_IN        = 18,
    parameter int MAX_AVG_LOG = 7,
    parameter int AVG_LOG_W   = 3
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 clear,
    input  logic                 strobe,
    input  logic [W_IN-1:0]      word,
    input  logic [AVG_LOG_W-1:0] avg_log,
    input  logic                 issue_ack,
    output logic [W_IN-1:0]      res,
    output logic                 pend,
    output logic                 overrun
);

    localparam int W_ACC = W_IN + MAX_AVG_LOG;
    localparam int CNT_W = (MAX_AVG_LOG > 0) ? MAX_AVG_LOG : 1;

    logic signed [W_ACC-1:0] acc_reg;
    logic signed [W_ACC-1:0] word_ext;
    logic signed [W_ACC-1:0] sum_next;
    logic [W_IN-1:0]         avg_trunc;
    logic [CNT_W-1:0]        cnt_reg;
    logic [CNT_W-1:0]        cnt_limit;
    logic                    block_done;
    logic [W_IN-1:0]         res_reg;
    logic                    pend_reg;
    logic                    overrun_reg;

    always_comb begin
        word_ext   = W_ACC'($signed(word));
        sum_next   = acc_reg + word_ext;
        // Arithmetic shift floors toward -inf; the mean always fits back into W_IN bits.
        avg_trunc  = W_IN'(sum_next >>> avg_log);
        cnt_limit  = ~({CNT_W{1'b1}} << avg_log);
        block_done = strobe && (cnt_reg == cnt_limit);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            acc_reg     <= '0;
            cnt_reg     <= '0;
            res_reg     <= '0;
            pend_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (clear) begin
            acc_reg  <= '0;
            cnt_reg  <= '0;
            pend_reg <= 1'b0;
        end else if (block_done) begin
            // A fresh result beats a same-cycle issue: it stays pending.
            res_reg  <= avg_trunc;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            pend_reg <= 1'b1;
            if (pend_reg && !issue_ack) begin
                overrun_reg <= 1'b1;
            end
        end else begin
            if (strobe) begin
                acc_reg <= sum_next;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (issue_ack) begin
                pend_reg <= 1'b0;
            end
        end
    end

    assign res     = res_reg;
    assign pend    = pend_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/adc_sample_averager.sv
// Block-averages per-channel ADC words from two serial ports and issues the results one
// at a time, lowest channel first, on a valid/ready port tagged with the channel index.
module adc_sample_averager
    import adc_sample_averager_pkg::*;
#(
    parameter int W_IN        = W_ADC,
    parameter int N_CHAN      = N_ADC_CHAN,
    parameter int MAX_AVG_LOG = adc_sample_averager_pkg::MAX_AVG_LOG,
    parameter int CHAN_W      = idx_width(N_CHAN)
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [N_CHAN-1:0] data_valid_in,
    input  logic [W_IN-1:0]   data_a_in,
    input  logic [W_IN-1:0]   data_b_in,
    input  logic [2:0]        avg_log_in,
    input  logic [N_CHAN-1:0] chan_en_in,
    input  logic              ready_in,
    output logic [W_IN-1:0]   data_out,
    output logic [CHAN_W-1:0] chan_out,
    output logic              valid_out,
    output logic [N_CHAN-1:0] overrun_out
);

    localparam int AVG_LOG_W = idx_width(MAX_AVG_LOG + 1);

    logic [AVG_LOG_W-1:0] avg_log_clamped;
    logic [AVG_LOG_W-1:0] avg_log_reg;
    logic                 avg_change;

    logic [N_CHAN-1:0]    pend;
    logic [N_CHAN-1:0]    issue_ack;
    logic [N_CHAN-1:0]    overrun;
    logic [W_IN-1:0]      res_arr [N_CHAN];

    logic [CHAN_W-1:0]    sel_idx;
    logic                 any_pend;
    logic                 load;

    logic [W_IN-1:0]      data_reg;
    logic [CHAN_W-1:0]    chan_reg;
    logic                 valid_reg;

    always_comb begin
        if (32'(avg_log_in) > MAX_AVG_LOG) begin
            avg_log_clamped = AVG_LOG_W'(MAX_AVG_LOG);
        end else begin
            avg_log_clamped = AVG_LOG_W'(avg_log_in);
        end
        avg_change = (avg_log_clamped != avg_log_reg);
    end

    // The registered copy drives the channels, so a change cycle's samples see a clear.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            avg_log_reg <= '0;
        end else begin
            avg_log_reg <= avg_log_clamped;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
            logic [W_IN-1:0] word;
            assign word = (gi < N_CHAN / 2) ? data_a_in : data_b_in;
            assign issue_ack[gi] = load && (sel_idx == CHAN_W'(gi));

            adc_sample_averager_chan_accum #(
                .W_IN        (W_IN),
                .MAX_AVG_LOG (MAX_AVG_LOG),
                .AVG_LOG_W   (AVG_LOG_W)
            ) u_accum (
                .clk       (clk_in),
                .srst      (reset_in),
                .clear     (avg_change || !chan_en_in[gi]),
                .strobe    (data_valid_in[gi] && chan_en_in[gi]),
                .word      (word),
                .avg_log   (avg_log_reg),
                .issue_ack (issue_ack[gi]),
                .res       (res_arr[gi]),
                .pend      (pend[gi]),
                .overrun   (overrun[gi])
            );
        end
    endgenerate

    // Scanning downward leaves the lowest pending index selected.
    always_comb begin
        sel_idx = '0;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_idx = CHAN_W'(i);
            end
        end
        any_pend = |pend;
        load     = any_pend && (!valid_reg || ready_in);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            data_reg  <= '0;
            chan_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= res_arr[sel_idx];
            chan_reg  <= sel_idx;
            valid_reg <= 1'b1;
        end else if (ready_in) begin
            valid_reg <= 1'b0;
        end
    end

    assign data_out    = data_reg;
    assign chan_out    = chan_reg;
    assign valid_out   = valid_reg;
    assign overrun_out = overrun;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench for adc_sample_averager: expected (channel, mean) pairs are queued as
// blocks are driven and popped as the DUT hands results over the valid/ready port.
module tb_adc_sample_averager;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [7:0]  data_valid_in;
    logic [17:0] data_a_in;
    logic [17:0] data_b_in;
    logic [2:0]  avg_log_in;
    logic [7:0]  chan_en_in;
    logic        ready_in;
    logic [17:0] data_out;
    logic [2:0]  chan_out;
    logic        valid_out;
    logic [7:0]  overrun_out;

    typedef struct {
        int chan;
        int data;
    } exp_t;

    exp_t sb[$];
    int   vals[8];
    int   total = 0;
    int   bad   = 0;
    int   want_v;
    int   dummy_v;

    always #5 clk_in = ~clk_in;

    adc_sample_averager dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .data_valid_in (data_valid_in),
        .data_a_in     (data_a_in),
        .data_b_in     (data_b_in),
        .avg_log_in    (avg_log_in),
        .chan_en_in    (chan_en_in),
        .ready_in      (ready_in),
        .data_out      (data_out),
        .chan_out      (chan_out),
        .valid_out     (valid_out),
        .overrun_out   (overrun_out)
    );

    task automatic check_val(input string tag, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // A word transfers on the edge after a negedge that sees valid & ready.
    always @(negedge clk_in) begin
        if (!reset_in && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                check_val("spurious_out_sb_size", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("out_chan", chan_out, e.chan);
                check_val("out_data", $signed(data_out), e.data);
                $display("xfer chan=%0d data=%0d exp_chan=%0d exp_data=%0d",
                         chan_out, $signed(data_out), e.chan, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_one(input int ch, input int v);
        data_valid_in = 8'(1 << ch);
        if (ch < 4) data_a_in = 18'(v);
        else        data_b_in = 18'(v);
        tick();
        data_valid_in = '0;
    endtask

    task automatic send_block(input int ch, input int lg, output int want);
        longint s = 0;
        for (int k = 0; k < (1 << lg); k++) begin
            s += vals[k];
            send_one(ch, vals[k]);
        end
        want = int'(s >>> lg);
    endtask

    task automatic set_avg(input int lg);
        avg_log_in = 3'(lg);
        tick();
        tick();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || valid_out) && n < 300) begin
            tick();
            n++;
        end
        check_val(tag, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_in      = 1'b1;
        data_valid_in = '0;
        data_a_in     = '0;
        data_b_in     = '0;
        avg_log_in    = 3'd0;
        chan_en_in    = 8'hff;
        ready_in      = 1'b1;
        repeat (3) tick();
        reset_in = 1'b0;
        check_val("rst_valid", valid_out, 0);
        check_val("rst_data", data_out, 0);
        check_val("rst_chan", chan_out, 0);
        check_val("rst_overrun", overrun_out, 0);
        tick();

        // Passthrough, both ports strobed together; lower channel issues first.
        sb.push_back('{0, -5});
        sb.push_back('{4, 7});
        data_valid_in = 8'h11;
        data_a_in     = 18'(-5);
        data_b_in     = 18'(7);
        tick();
        data_valid_in = '0;
        @(negedge clk_in);
        check_val("t1_lat_k1_valid", valid_out, 0);
        @(negedge clk_in);
        check_val("t1_lat_k2_valid", valid_out, 1);
        tick();
        drain("t1_drain");

        // Four-sample block: nothing until the fourth sample lands.
        set_avg(2);
        send_one(1, 10);
        send_one(1, 11);
        send_one(1, 12);
        repeat (3) tick();
        check_val("t2_early_valid", valid_out, 0);
        sb.push_back('{1, 8});
        send_one(1, -1);
        drain("t2_drain");

        // Floor rounding of a negative mean, then full-scale blocks on both ports.
        set_avg(1);
        vals[0] = -3; vals[1] = -4;
        send_block(2, 1, want_v);
        sb.push_back('{2, want_v});
        drain("t3_neg_drain");
        set_avg(2);
        for (int k = 0; k < 4; k++) vals[k] = 131071;
        send_block(7, 2, want_v);
        sb.push_back('{7, want_v});
        for (int k = 0; k < 4; k++) vals[k] = -131072;
        send_block(3, 2, want_v);
        sb.push_back('{3, want_v});
        drain("t3_fs_drain");

        // Stall: first result held, second overwritten by third -> overrun.
        set_avg(1);
        ready_in = 1'b0;
        vals[0] = 100; vals[1] = 102;
        send_block(3, 1, want_v);
        sb.push_back('{3, want_v});
        repeat (3) tick();
        check_val("t4_held_valid", valid_out, 1);
        check_val("t4_held_data", $signed(data_out), 101);
        vals[0] = 200; vals[1] = 202;
        send_block(3, 1, dummy_v);
        tick();
        check_val("t4_no_overrun_yet", overrun_out, 0);
        vals[0] = -50; vals[1] = -51;
        send_block(3, 1, want_v);
        sb.push_back('{3, want_v});
        repeat (2) tick();
        check_val("t4_overrun", overrun_out, 8'h08);
        check_val("t4_hold_data", $signed(data_out), 101);
        check_val("t4_hold_chan", chan_out, 3);
        ready_in = 1'b1;
        drain("t4_drain");
        check_val("t4_overrun_sticky", overrun_out, 8'h08);

        // Block length change discards a partial block.
        set_avg(3);
        for (int k = 0; k < 5; k++) send_one(0, 1000);
        set_avg(2);
        vals[0] = 20; vals[1] = 21; vals[2] = 22; vals[3] = 23;
        send_block(0, 2, want_v);
        sb.push_back('{0, want_v});
        drain("t5_drain");

        // Disabled channel ignores strobes.
        set_avg(0);
        chan_en_in = 8'hbf;
        send_one(6, 55);
        repeat (4) tick();
        check_val("t6_disabled_valid", valid_out, 0);
        chan_en_in = 8'hff;
        tick();

        // Reset with a held word and a partial block in flight.
        set_avg(2);
        ready_in = 1'b0;
        vals[0] = 4; vals[1] = 8; vals[2] = 12; vals[3] = 16;
        send_block(5, 2, want_v);
        sb.push_back('{5, want_v});
        repeat (3) tick();
        check_val("t7_pre_valid", valid_out, 1);
        send_one(1, 999);
        send_one(1, 999);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        sb.delete();
        check_val("t7_rst_valid", valid_out, 0);
        check_val("t7_rst_data", data_out, 0);
        check_val("t7_rst_chan", chan_out, 0);
        check_val("t7_rst_overrun", overrun_out, 0);
        ready_in = 1'b1;
        tick();
        send_one(1, 40);
        send_one(1, 44);
        repeat (4) tick();
        check_val("t7_no_stale_valid", valid_out, 0);
        sb.push_back('{1, 46});
        send_one(1, 48);
        send_one(1, 52);
        drain("t7_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
